and4_result_fifo: RTL

Downstream capture stage for the `and4` datapath. It takes each operand/result triple (`a`, `b`, `y`) from the AND unit's interface under a valid/ready handshake and buffers it in a small FIFO. It presents the triples in order to the consumer, a scoreboard or a later pipeline stage. On every push it checks `y == a & b` and records mismatches, so a faulty AND stage is flagged at the point of capture.

---
 rtl/and4_pkg.sv | 17 +
 rtl/and4_result_fifo.sv | 98 +++++++++
 2 files changed

// File: rtl/and4_pkg.sv
// Shared types and constants for the and4 capture path.
package and4_pkg;

    // Operand/result width of the and4 datapath.
    localparam int WIDTH = 4;

    // err_cnt stops counting at this value.
    localparam int ERR_CNT_MAX = 255;

    // One captured operand/result triple, as held in the FIFO storage.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
    } and4_rec_t;

endpackage

// File: rtl/and4_result_fifo.sv
// Capture FIFO behind the and4 unit. Buffers (a, b, y) triples in order and
// flags any pushed triple whose result is not a & b. Bad triples are still
// stored and forwarded; the checker only reports them.
module and4_result_fifo
    import and4_pkg::*;
#(
    // The storage record is sized by and4_pkg::WIDTH, so this must match it.
    parameter int WIDTH = and4_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [WIDTH-1:0]         out_y,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mismatch,
    output logic [7:0]               err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    and4_rec_t        mem [DEPTH];
    and4_rec_t        head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bad;

    // Occupancy is tracked by an explicit counter, so full/empty never depend
    // on comparing pointers. in_ready uses only registered state and rst, so
    // a pop never reaches in_ready in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !rst && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !rst;
    assign bad       = push && (in_y != (in_a & in_b));

    assign head  = mem[rd_ptr];
    assign out_a = head.a;
    assign out_b = head.b;
    assign out_y = head.y;

    // Storage write; contents are not cleared by reset, only made unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= and4_rec_t'{a: in_a, b: in_b, y: in_y};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result checker: sticky flag plus saturating count of bad pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (bad) begin
            mismatch <= 1'b1;
            if (err_cnt != 8'(ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
